seg_counter: RTL and testbench
==============================

SEG_COUNTER -- requirements
Module: seg_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized-input cycles before a debounced level changes; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 btn_inc  input  1  raw asynchronous pushbutton, active-high, increment request.
REQ-005 btn_dec  input  1  raw asynchronous pushbutton, active-high, decrement request.
REQ-006 clr  input  1  synchronous clear of the count, active-high, level-sensitive, already clk-synchronous.
REQ-007 count  output  16  registered BCD count; [3:0] is digit0, the least-significant digit, and [15:12] is digit3.
REQ-008 seg0, seg1, seg2, seg3  output  7 each  registered active-high segment pattern for digits 0..3.
  - Bit order: bit0=a, bit1=b, bit2=c, bit3=d, bit4=f, bit5=g, bit6=e.
  - Each bus feeds the w0..w6 inputs of the downstream active-low hex display stage.

Function
REQ-009 Each button SHALL pass through its own two-flop synchronizer before any other logic sees it.
REQ-010 Each button SHALL have an independent debouncer with a debounced level db and a counter cnt (16 bits):
  - When the synchronizer output equals db, cnt clears.
  - Otherwise cnt increments.
  - When cnt reaches DEBOUNCE_CYCLES-1 while the inputs still differ, db takes the synchronizer value and cnt clears.
REQ-011 A 0->1 transition of db SHALL generate a one-cycle registered step pulse. A 1->0 transition generates nothing. Holding a button generates exactly one step.
REQ-012 Latency: a button held high from before edge E0 SHALL raise db at edge E0+1+DEBOUNCE_CYCLES, update count at edge E0+2+DEBOUNCE_CYCLES, and update seg* at edge E0+3+DEBOUNCE_CYCLES.
REQ-013 An increment step SHALL add 1 in BCD with carry between digits; 9999 wraps to 0000.
REQ-014 A decrement step SHALL subtract 1 in BCD with borrow between digits; 0000 wraps to 9999.
REQ-015 Increment and decrement steps in the same cycle SHALL leave count unchanged.
REQ-016 clr high SHALL load count 0000 on that edge, overriding any step in the same cycle. Steps arriving while clr is high are discarded.
REQ-017 Debouncers SHALL keep running during clr.
REQ-018 No digit SHALL ever hold a value above 9.
REQ-019 The seg* outputs SHALL be registered from count, one cycle behind it. Patterns for digits 0..9: 5F, 06, 6B, 2F, 36, 3D, 7D, 07, 7F, 3F (hex).

Reset
REQ-020 With rst_n low at a rising edge, the block SHALL reset all state:
  - count = 0000 and seg0..seg3 = 5F;
  - synchronizers, db levels, cnt and step pulses = 0.
REQ-021 Reset SHALL override clr and steps. A button already held at reset release SHALL produce one step after DEBOUNCE_CYCLES+3 edges, because db restarts at 0.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count, and no step SHALL follow from the pre-reset press.

Configuration
REQ-023 Macro SEG_COUNTER_BLANK_EN controls leading-zero blanking.
  - Defined: digit k (k=1..3) SHALL output 00 whenever it and every higher digit are 0; digit0 is never blanked. Example: count 0042 gives seg3=00, seg2=00, seg1=36, seg0=6B.
  - Undefined: all four digits always show their patterns, so count 0042 gives seg3=5F, seg2=5F.

Verification
Scenarios use DEBOUNCE_CYCLES=4.
REQ-024 Reset, then idle for 10 cycles -> count=0000, all seg*=5F (macro off) and seg3..seg1=00, seg0=5F (macro on).
REQ-025 btn_inc high from edge E0 and held for 20 cycles -> count=0001 exactly at edge E0+6, seg0=06 at edge E0+7, and no further change.
REQ-026 btn_inc pulses high for 2 cycles, repeated with a 2-cycle gap for 40 cycles -> count stays 0000 (bounce rejected).
REQ-027 From 0000, one decrement press -> count=9999, all seg*=3F. Then one increment press -> 0000.
REQ-028 Preload count to 0099 and press increment -> 0100, seg2=06, seg1=5F, seg0=5F. Press both buttons in the same cycle -> count unchanged.
REQ-029 Assert clr on the same edge that an increment step is due -> count=0000. Assert rst_n low while the decrement debounce counter is at 2 -> no step after release.

Source files
------------

// File: rtl/seg_counter.sv
// ---------------------------------------------------------------------------
// seg_counter
//   Four-digit BCD up/down counter. Two raw pushbuttons each pass through a
//   two-flop synchronizer and a debouncer. A debounced press produces one
//   step. The count is then driven onto four 7-segment pattern buses.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronized cycles needed before a
//                     debounced level changes (legal range 2..65535).
//
// Ports
//   clk      : sole clock, rising edge
//   rst_n    : synchronous active-low reset
//   btn_inc  : raw asynchronous increment button, active-high
//   btn_dec  : raw asynchronous decrement button, active-high
//   clr      : synchronous level-sensitive clear of the count
//   count    : registered BCD count, [3:0] = digit0 ... [15:12] = digit3
//   seg0..3  : registered active-high segment patterns for digits 0..3,
//              bit order {e,g,f,d,c,b,a} from bit6 down to bit0
//
// Configuration
//   SEG_COUNTER_BLANK_EN : when defined, leading zeros on digits 3..1 are
//                          blanked (pattern 00); digit0 is never blanked.
// ---------------------------------------------------------------------------
module seg_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        clr,
    output logic [15:0] count,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3
);

    localparam int unsigned NUM_BTN   = 2;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SEG_W     = 7;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    // Index 0 is the increment button, index 1 the decrement button.
    localparam int unsigned IDX_INC = 0;
    localparam int unsigned IDX_DEC = 1;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'h5F;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Segment pattern for one BCD digit; non-decimal codes are never produced
    // by the counter and map to a dark digit.
    function automatic logic [SEG_W-1:0] seg_pattern(input logic [3:0] d);
        logic [SEG_W-1:0] p;
        case (d)
            4'd0:    p = 7'h5F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h6B;
            4'd3:    p = 7'h2F;
            4'd4:    p = 7'h36;
            4'd5:    p = 7'h3D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h3F;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // BCD +1 with ripple carry; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with ripple borrow; 0000 wraps to 9999.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Synchronizers, debouncers and step pulses
    // -----------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync_a;
    logic [NUM_BTN-1:0] sync_b;
    logic [NUM_BTN-1:0] db;
    logic [NUM_BTN-1:0] step;
    logic [CNT_W-1:0]   cnt [NUM_BTN];

    logic [NUM_BTN-1:0] db_next;
    logic [NUM_BTN-1:0] step_next;
    logic [CNT_W-1:0]   cnt_next [NUM_BTN];

    assign btn_raw = {btn_dec, btn_inc};

    // Debounce next state: cnt counts consecutive disagreeing cycles; on the
    // last one db adopts the synchronized value. The step pulse is produced
    // on the same edge db rises, so the count follows one edge later.
    always_comb begin
        db_next   = db;
        step_next = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            cnt_next[i] = '0;
            if (sync_b[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_next[i]   = sync_b[i];
                    step_next[i] = sync_b[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Button-path registers; these keep running regardless of clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            db     <= '0;
            step   <= '0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            db     <= db_next;
            step   <= step_next;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // BCD count
    // -----------------------------------------------------------------------
    logic [15:0] count_next;

    // clr wins over steps; simultaneous inc and dec cancel.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (step[IDX_INC] && !step[IDX_DEC]) begin
            count_next = bcd_inc(count);
        end else if (step[IDX_DEC] && !step[IDX_INC]) begin
            count_next = bcd_dec(count);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // -----------------------------------------------------------------------
    // Segment outputs, one cycle behind count
    // -----------------------------------------------------------------------
    logic blank1;
    logic blank2;
    logic blank3;

`ifdef SEG_COUNTER_BLANK_EN
    // A digit is blanked only when it and every more-significant digit are 0.
    assign blank3 = (count[15:12] == 4'd0);
    assign blank2 = blank3 && (count[11:8] == 4'd0);
    assign blank1 = blank2 && (count[7:4] == 4'd0);
`else
    assign blank3 = 1'b0;
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    logic [SEG_W-1:0] seg0_next;
    logic [SEG_W-1:0] seg1_next;
    logic [SEG_W-1:0] seg2_next;
    logic [SEG_W-1:0] seg3_next;

    always_comb begin
        seg0_next = seg_pattern(count[3:0]);
        seg1_next = blank1 ? SEG_BLANK : seg_pattern(count[7:4]);
        seg2_next = blank2 ? SEG_BLANK : seg_pattern(count[11:8]);
        seg3_next = blank3 ? SEG_BLANK : seg_pattern(count[15:12]);
    end

    // Reset shows an unblanked 0 on every digit regardless of blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg0 <= SEG_ZERO;
            seg1 <= SEG_ZERO;
            seg2 <= SEG_ZERO;
            seg3 <= SEG_ZERO;
        end else begin
            seg0 <= seg0_next;
            seg1 <= seg1_next;
            seg2 <= seg2_next;
            seg3 <= seg3_next;
        end
    end

endmodule

// File: tb/tb_seg_counter.sv
// ---------------------------------------------------------------------------
// tb_seg_counter
//   Scoreboard bench for seg_counter with DEBOUNCE_CYCLES = 4. A behavioural
//   model (integer count, raw-sample history, run-length debounce) predicts
//   every count change with its edge number; a monitor pops and compares
//   each time the DUT count moves, then checks the segments one cycle later.
//   Honours SEG_COUNTER_BLANK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_seg_counter;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] count;
    logic [6:0]  seg0, seg1, seg2, seg3;

    seg_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .clr     (clr),
        .count   (count),
        .seg0    (seg0),
        .seg1    (seg1),
        .seg2    (seg2),
        .seg3    (seg3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [6:0] PAT [10] = '{7'h5F, 7'h06, 7'h6B, 7'h2F, 7'h36,
                                        7'h3D, 7'h7D, 7'h07, 7'h7F, 7'h3F};

    function automatic logic [15:0] to_bcd(input int c);
        return {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
    endfunction

    // {seg3, seg2, seg1, seg0} for an integer count 0..9999.
    function automatic logic [27:0] exp_segs(input int c);
        logic [27:0] r;
        int          div;
        logic [6:0]  p;
        r   = '0;
        div = 1;
        for (int k = 0; k < 4; k++) begin
            p = PAT[(c / div) % 10];
`ifdef SEG_COUNTER_BLANK_EN
            if (k > 0 && c < div) p = 7'h00;
`endif
            r[k*7 +: 7] = p;
            div = div * 10;
        end
        return r;
    endfunction

    typedef struct {
        int          edge_no;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          m_count = 0;
    logic [27:0] m_segs = {4{7'h5F}};
    bit          h_inc[$];
    bit          h_dec[$];
    bit          m_db[2] = '{0, 0};
    int          m_run[2] = '{0, 0};
    bit          pend[2] = '{0, 0};

    always @(posedge clk) begin
        int old;
        bit obs[2];
        bit rise[2];
        cyc++;
        old = m_count;
        if (!rst_n) begin
            m_count = 0;
            m_segs  = {4{7'h5F}};
            h_inc.delete();
            h_dec.delete();
            for (int i = 0; i < 2; i++) begin
                m_db[i] = 0; m_run[i] = 0; pend[i] = 0;
            end
        end else begin
            m_segs = exp_segs(m_count);
            if (clr) m_count = 0;
            else if (pend[0] && !pend[1]) m_count = (m_count + 1) % 10000;
            else if (pend[1] && !pend[0]) m_count = (m_count + 9999) % 10000;
            // The debouncer sees the raw level sampled two edges ago.
            obs[0] = (h_inc.size() >= 2) ? h_inc[h_inc.size() - 2] : 1'b0;
            obs[1] = (h_dec.size() >= 2) ? h_dec[h_dec.size() - 2] : 1'b0;
            h_inc.push_back(btn_inc);
            h_dec.push_back(btn_dec);
            if (h_inc.size() > 3) void'(h_inc.pop_front());
            if (h_dec.size() > 3) void'(h_dec.pop_front());
            for (int i = 0; i < 2; i++) begin
                rise[i] = 0;
                if (obs[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_db[i]  = obs[i];
                        m_run[i] = 0;
                        rise[i]  = obs[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
                pend[i] = rise[i];
            end
        end
        if (m_count != old) sb_q.push_back('{cyc, to_bcd(m_count)});
    end

    // ---------------- monitor ----------------
    bit          mon_en = 0;
    bit          seg_due = 0;
    logic [15:0] last_seen = 16'h0000;
    int          last_change_edge = 0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (seg_due) begin
                check("seg_after_count", 32'({seg3, seg2, seg1, seg0}), 32'(m_segs));
                seg_due = 0;
            end
            if (count !== last_seen) begin
                if (sb_q.size() == 0) begin
                    check("count_unexpected", 32'(count), 32'(last_seen));
                end else begin
                    e = sb_q.pop_front();
                    check("count_value", 32'(count), 32'(e.val));
                    check("count_edge", 32'(cyc), 32'(e.edge_no));
                end
                last_seen        = count;
                last_change_edge = cyc;
                seg_due          = 1;
            end
            while (sb_q.size() > 0 && sb_q[0].edge_no < cyc) begin
                e = sb_q.pop_front();
                check("count_late", 32'(count), 32'(e.val));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input bit inc, input bit dec, input int hold);
        btn_inc = inc;
        btn_dec = dec;
        tick(hold);
        btn_inc = 0;
        btn_dec = 0;
        tick(10);
    endtask

    task automatic wait_edge(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic check_model(input string name);
        check({name, "_count"}, 32'(count), 32'(to_bcd(m_count)));
        check({name, "_segs"}, 32'({seg3, seg2, seg1, seg0}), 32'(m_segs));
    endtask

    logic [27:0] idle_segs;
    int          e0;
    int          inc_left, dec_left;

    initial begin
`ifdef SEG_COUNTER_BLANK_EN
        idle_segs = {7'h00, 7'h00, 7'h00, 7'h5F};
`else
        idle_segs = {4{7'h5F}};
`endif
        tick(3);
        check("reset_count", 32'(count), 32'h0000);
        check("reset_segs", 32'({seg3, seg2, seg1, seg0}), 32'({4{7'h5F}}));
        rst_n  = 1;
        mon_en = 1;
        tick(10);
        check("idle_count", 32'(count), 32'h0000);
        check("idle_segs", 32'({seg3, seg2, seg1, seg0}), 32'(idle_segs));

        // Bounce: 2 high / 2 low never survives a 4-cycle debounce.
        for (int i = 0; i < 10; i++) begin
            btn_inc = 1; tick(2);
            btn_inc = 0; tick(2);
        end
        tick(10);
        check("bounce_count", 32'(count), 32'h0000);

        // Held press: exactly one step, count at E0+6.
        e0 = cyc + 1;
        press(1, 0, 20);
        check("hold_count", 32'(count), 32'h0001);
        check("hold_edge", 32'(last_change_edge), 32'(e0 + 6));
        check("hold_seg0", 32'(seg0), 32'h06);

        // Wrap down and back up.
        rst_n = 0; tick(2); rst_n = 1; tick(2);
        press(0, 1, 8);
        check("wrap_dn_count", 32'(count), 32'h9999);
        check("wrap_dn_segs", 32'({seg3, seg2, seg1, seg0}), 32'({4{7'h3F}}));
        press(1, 0, 8);
        check("wrap_up_count", 32'(count), 32'h0000);

        // Build 0099, then carry into the hundreds.
        for (int i = 0; i < 99; i++) press(1, 0, 8);
        check("preload_count", 32'(count), 32'h0099);
        press(1, 0, 8);
        check("carry_count", 32'(count), 32'h0100);
        check("carry_seg2", 32'(seg2), 32'h06);
        check("carry_seg1", 32'(seg1), 32'h5F);
        check("carry_seg0", 32'(seg0), 32'h5F);
`ifdef SEG_COUNTER_BLANK_EN
        check("carry_seg3", 32'(seg3), 32'h00);
`else
        check("carry_seg3", 32'(seg3), 32'h5F);
`endif
        press(1, 1, 8);
        check("both_count", 32'(count), 32'h0100);

        // clr on the very edge the increment step lands.
        e0 = cyc + 1;
        btn_inc = 1;
        wait_edge(e0 + 5);
        clr = 1;
        tick(1);
        clr = 0;
        tick(8);
        btn_inc = 0;
        tick(10);
        check("clr_count", 32'(count), 32'h0000);
        check("clr_edge", 32'(last_change_edge), 32'(e0 + 6));

        // Reset while the decrement debounce counter is at 2.
        e0 = cyc + 1;
        btn_dec = 1;
        wait_edge(e0 + 3);
        rst_n = 0;
        btn_dec = 0;
        tick(1);
        rst_n = 1;
        tick(20);
        check("midreset_count", 32'(count), 32'h0000);

        // Button held through reset release still yields one step.
        btn_inc = 1;
        rst_n = 0;
        tick(2);
        rst_n = 1;
        e0 = cyc + 1;
        tick(12);
        btn_inc = 0;
        tick(10);
        check("held_reset_count", 32'(count), 32'h0001);
        check("held_reset_edge", 32'(last_change_edge), 32'(e0 + 6));

        // Random run lengths straddling the debounce window.
        inc_left = 0;
        dec_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (inc_left == 0) begin
                btn_inc  = ~btn_inc;
                inc_left = int'($urandom_range(1, 12));
            end
            if (dec_left == 0) begin
                btn_dec  = ~btn_dec;
                dec_left = int'($urandom_range(1, 12));
            end
            inc_left--;
            dec_left--;
            clr   = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick(1);
        end
        rst_n   = 1;
        clr     = 0;
        btn_inc = 0;
        btn_dec = 0;
        tick(20);
        check_model("final");
        check("queue_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
